bundled_data_sender: RTL and testbench

Transmit end of the four-phase bundled-data link: accepts bytes from a synchronous valid/ready producer, buffers them in a small FIFO, and drives them onto an outgoing data bundle with a request/acknowledge handshake toward an asynchronous or foreign-clock receiver. The sender guarantees data stability for a programmable setup time before raising the request. It synchronizes the returning acknowledge, and sequences one word per full handshake.

---
 rtl/bundled_data_pkg.sv | 13 +
 rtl/bds_fifo.sv | 68 ++++++
 rtl/bundled_data_sender.sv | 143 ++++++++++++++
 tb/tb_bundled_data_sender.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/bundled_data_pkg.sv
// Shared types for the bundled-data sender: FSM state encoding and default bundle width.
package bundled_data_pkg;

  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } bds_state_t;

endpackage

// File: rtl/bds_fifo.sv
// Synchronous FIFO, zero-latency head (first-word fall-through), full/empty registered.
// Push ignored when full, pop ignored when empty; simultaneous push+pop keeps the count.
module bds_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_next;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage needs no reset: empty/full gate every read of stale entries.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/bundled_data_sender.sv
// Four-phase bundled-data transmitter: FIFO -> data_out, req after SETUP_CYCLES, 2-flop ack sync.
// in_ready = !full (registered); optional ack-timeout flag under BUNDLED_DATA_SENDER_TIMEOUT_EN.
module bundled_data_sender
  import bundled_data_pkg::*;
#(
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int DEPTH          = 4,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              req_out,
  input  logic              ack_in,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
  localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);

  bds_state_t        state;
  logic [CW-1:0]     cnt;
  logic              ack_meta;
  logic              ack_s;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              pop;

  bds_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign busy     = (state != IDLE) || !fifo_empty;

  // A word is taken only while the receiver's ack is seen low.
  assign pop = !ack_s && !fifo_empty && ((state == IDLE) || (state == REQ_LO));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= ack_in;
      ack_s    <= ack_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      data_out <= '0;
      req_out  <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            data_out <= fifo_head;
            cnt      <= SETUP_LOAD;
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            req_out <= 1'b1;
            state   <= REQ_HI;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        REQ_HI: begin
          if (ack_s) begin
            req_out <= 1'b0;
            state   <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (!ack_s) begin
            if (pop) begin
              data_out <= fifo_head;
              cnt      <= SETUP_LOAD;
              state    <= SETUP;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BUNDLED_DATA_SENDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          tmo_err;
  logic          waiting;
  logic          leaving;

  assign waiting     = (state == REQ_HI) || (state == REQ_LO);
  assign leaving     = ((state == REQ_HI) && ack_s) || ((state == REQ_LO) && !ack_s);
  assign timeout_err = tmo_err;

  // Flag only; the handshake keeps waiting for the receiver.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
    end else if (!waiting || leaving) begin
      tmo_cnt <= '0;
    end else begin
      if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        tmo_err <= 1'b1;
      end
    end
  end
`else
  // Timeout hardware absent; the parameter is kept so both builds share one interface.
  assign timeout_err = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_bundled_data_sender.sv
// Directed self-checking bench for bundled_data_sender (DEPTH=4, SETUP_CYCLES=2, TIMEOUT_CYCLES=16).
module tb_bundled_data_sender;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] data_out;
  logic       req_out;
  logic       ack_in;
  logic       busy;
  logic       timeout_err;

  int checks = 0;
  int errors = 0;
  bit pend   = 1'b0;

  always #5 clk = ~clk;

  bundled_data_sender #(
    .DATA_W         (8),
    .DEPTH          (4),
    .SETUP_CYCLES   (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .data_out    (data_out),
    .req_out     (req_out),
    .ack_in      (ack_in),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; a posted push retires at the edge where in_ready was high.
  task automatic tick();
    logic acc;
    acc = pend && in_valid && in_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      pend     = 1'b0;
      in_valid = 1'b0;
    end
  endtask

  task automatic post(input logic [7:0] d);
    pend     = 1'b1;
    in_valid = 1'b1;
    in_data  = d;
  endtask

  task automatic push_word(input logic [7:0] d, input string tag);
    int n = 0;
    post(d);
    while (pend && n < 200) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, pend}, 32'd0);
  endtask

  task automatic wait_req(input logic lvl, input string tag);
    int n = 0;
    while (req_out !== lvl && n < 200) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, req_out}, {31'd0, lvl});
  endtask

  task automatic handshake(input logic [7:0] exp, input int ack_dly, input int drop_dly, input string tag);
    wait_req(1'b1, {tag, "_req_rise"});
    chk({tag, "_data_at_req"}, {24'd0, data_out}, {24'd0, exp});
    repeat (ack_dly) tick();
    chk({tag, "_data_before_ack"}, {24'd0, data_out}, {24'd0, exp});
    ack_in = 1'b1;
    wait_req(1'b0, {tag, "_req_fall"});
    chk({tag, "_data_at_req_fall"}, {24'd0, data_out}, {24'd0, exp});
    repeat (drop_dly) tick();
    ack_in = 1'b0;
  endtask

  task automatic quiet(input int n, input string tag);
    int rises = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (req_out === 1'b1) rises++;
    end
    chk(tag, rises, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    ack_in   = 1'b0;
    tick();
    tick();
    chk("rst_data_out", {24'd0, data_out}, 32'h0);
    chk("rst_req_out", {31'd0, req_out}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single word: load at N+1, req at N+3, ack 5 cycles after req, drop 3 after req falls.
    post(8'hA5);
    tick();
    chk("a5_accepted", {31'd0, pend}, 32'd0);
    chk("a5_busy_queued", {31'd0, busy}, 32'd1);
    chk("a5_no_early_load", {24'd0, data_out}, 32'h0);
    tick();
    chk("a5_load", {24'd0, data_out}, 32'hA5);
    chk("a5_req_low_load", {31'd0, req_out}, 32'd0);
    tick();
    chk("a5_req_low_setup", {31'd0, req_out}, 32'd0);
    tick();
    chk("a5_req_rise", {31'd0, req_out}, 32'd1);
    repeat (5) tick();
    ack_in = 1'b1;
    tick();
    chk("a5_req_sync1", {31'd0, req_out}, 32'd1);
    tick();
    chk("a5_req_sync2", {31'd0, req_out}, 32'd1);
    tick();
    chk("a5_req_fall", {31'd0, req_out}, 32'd0);
    chk("a5_data_hold", {24'd0, data_out}, 32'hA5);
    repeat (3) tick();
    ack_in = 1'b0;
    tick();
    tick();
    chk("a5_busy_in_req_lo", {31'd0, busy}, 32'd1);
    tick();
    chk("a5_idle_busy", {31'd0, busy}, 32'd0);
    chk("a5_data_kept", {24'd0, data_out}, 32'hA5);

    // Six words through a 4-deep FIFO with a receiver that has not yet answered.
    for (int i = 1; i <= 5; i++) begin
      push_word(8'(i), "burst_push");
    end
    chk("burst_full_in_ready", {31'd0, in_ready}, 32'd0);
    post(8'h06);
    repeat (3) tick();
    chk("burst_6_held", {31'd0, pend}, 32'd1);
    chk("burst_still_full", {31'd0, in_ready}, 32'd0);
    for (int i = 1; i <= 6; i++) begin
      handshake(8'(i), 2, 2, "burst");
    end
    chk("burst_6_accepted", {31'd0, pend}, 32'd0);
    quiet(20, "burst_no_dup");
    chk("burst_idle", {31'd0, busy}, 32'd0);
    chk("burst_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset while holding 0x3C in REQ_HI with a second word queued.
    push_word(8'h3C, "rst_push_3c");
    wait_req(1'b1, "rst_req_rise");
    chk("rst_hold_3c", {24'd0, data_out}, 32'h3C);
    push_word(8'h77, "rst_push_77");
    rst_n = 1'b0;
    tick();
    chk("midrst_req", {31'd0, req_out}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_data", {24'd0, data_out}, 32'h0);
    rst_n = 1'b1;
    quiet(20, "midrst_no_resend");
    chk("midrst_data_after", {24'd0, data_out}, 32'h0);

    // Stray ack held high in IDLE blocks the load until it drops.
    ack_in = 1'b1;
    repeat (3) tick();
    push_word(8'h5A, "stray_push");
    repeat (5) tick();
    chk("stray_no_load", {24'd0, data_out}, 32'h0);
    chk("stray_busy", {31'd0, busy}, 32'd1);
    ack_in = 1'b0;
    tick();
    tick();
    chk("stray_wait_sync", {24'd0, data_out}, 32'h0);
    tick();
    chk("stray_load", {24'd0, data_out}, 32'h5A);
    handshake(8'h5A, 5, 3, "stray");
    quiet(6, "stray_done");
    chk("stray_idle", {31'd0, busy}, 32'd0);

    // Receiver never acks: flag at edge 16 of REQ_HI only when the timeout is built.
    push_word(8'hC3, "tmo_push");
    wait_req(1'b1, "tmo_req_rise");
    repeat (15) tick();
    chk("tmo_edge15", {31'd0, timeout_err}, 32'd0);
    tick();
`ifdef BUNDLED_DATA_SENDER_TIMEOUT_EN
    chk("tmo_edge16", {31'd0, timeout_err}, 32'd1);
    repeat (30) tick();
    chk("tmo_sticky", {31'd0, timeout_err}, 32'd1);
`else
    chk("tmo_edge16_off", {31'd0, timeout_err}, 32'd0);
    repeat (30) tick();
    chk("tmo_off_later", {31'd0, timeout_err}, 32'd0);
`endif
    chk("tmo_still_waiting", {31'd0, req_out}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("tmo_cleared", {31'd0, timeout_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
